lsu: RTL and testbench

Load/store unit for the RV32I core's memory stage, directly downstream of the ALU. It takes the ALU-computed effective address plus the rs2 store data and performs one byte, halfword or word access on a word-addressed data-memory bus using a request/grant/rvalid handshake. It returns sign- or zero-extended load data, or a store completion, to writeback. Misaligned accesses are rejected without a bus transaction.

---
 rtl/types.sv | 26 ++
 rtl/load_extract.sv | 28 ++
 rtl/lsu.sv | 116 +++++++++++
 tb/tb_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// Shared core types: ALU control and memory-operation encodings emitted by decode.
package types;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_control_t;

  typedef enum logic [2:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Bytes never fault; halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/half out of a read word and sign/zero extends it.
module load_extract
  import types::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[8*offset +: 8];
  assign h = rdata[16*offset[1] +: 16];

  always_comb begin
    data = rdata;
    case (op)
      MEM_LB:  data = {{24{b[7]}}, b};
      MEM_LBU: data = {24'h0, b};
      MEM_LH:  data = {{16{h[15]}}, h};
      MEM_LHU: data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access per request over a req/gnt/rvalid bus.
module lsu
  import types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_op_t     mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  lsu_state_t  state;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_n, ld_data;
  logic [3:0]  wmask_n;
  logic        st_n, mis_n;

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign rsp_valid = (state == RESP);

  assign st_n  = is_store(mem_op);
  assign mis_n = misaligned(mem_op, addr[1:0]);

  // Store lanes: data replicated across the word, enables select the lane.
  always_comb begin
    wdata_n = '0;
    wmask_n = '0;
    case (mem_op)
      MEM_SB: begin
        wdata_n = {4{store_data[7:0]}};
        wmask_n = 4'b0001 << addr[1:0];
      end
      MEM_SH: begin
        wdata_n = {2{store_data[15:0]}};
        wmask_n = 4'b0011 << addr[1:0];
      end
      MEM_SW: begin
        wdata_n = store_data;
        wmask_n = 4'b1111;
      end
      default: ;
    endcase
  end

  load_extract u_extract (
    .op     (op_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= MEM_LB;
      off_q          <= '0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wmask      <= '0;
      mem_wdata      <= '0;
      rsp_data       <= '0;
      rsp_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q      <= mem_op;
          off_q     <= addr[1:0];
          mem_addr  <= {addr[31:2], 2'b00};
          mem_we    <= st_n;
          mem_wmask <= wmask_n;
          mem_wdata <= wdata_n;
          if (mis_n) begin
            rsp_data       <= '0;
            rsp_misaligned <= 1'b1;
            state          <= RESP;
          end else begin
            state <= REQ;
          end
        end
        REQ: if (mem_gnt) begin
          if (mem_we) begin
            rsp_data       <= '0;
            rsp_misaligned <= 1'b0;
            state          <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (mem_rvalid) begin
          rsp_data       <= ld_data;
          rsp_misaligned <= 1'b0;
          state          <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: transaction schedule model drives expectations, checked every cycle.
module tb_lsu;
  import types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  mem_op_t     mem_op;
  logic [31:0] addr, store_data;
  logic        rsp_valid, rsp_misaligned;
  logic [31:0] rsp_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int failures = 0;

  // expected values, advanced by the driver each cycle
  logic        e_ready, e_req, e_we, e_rsp, e_mis;
  logic [31:0] e_addr, e_wdata, e_out;
  logic [3:0]  e_mask;

  lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("rsp_data", rsp_data, e_out);
    chk("rsp_misaligned", 32'(rsp_misaligned), 32'(e_mis));
    if (e_req) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  // ---- behavioural model ----
  function automatic logic m_mis(mem_op_t op, logic [31:0] a);
    int o = int'(a % 4);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return (o % 2) != 0;
      MEM_LW, MEM_SW:          return o != 0;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic m_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [3:0] m_mask(mem_op_t op, logic [31:0] a);
    int o = int'(a % 4);
    case (op)
      MEM_SB:  return 4'(1 << o);
      MEM_SH:  return 4'(3 << o);
      MEM_SW:  return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(mem_op_t op, logic [31:0] sd);
    case (op)
      MEM_SB:  return (sd & 32'hFF) * 32'h01010101;
      MEM_SH:  return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(mem_op_t op, logic [31:0] a, logic [31:0] rd);
    int o = int'(a % 4);
    logic [31:0] b = (rd >> (8 * o)) & 32'hFF;
    logic [31:0] h = (rd >> (16 * (o / 2))) & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      MEM_LHU: return h;
      default: return rd;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      mem_gnt = 1'($urandom);
      mem_rvalid = 1'($urandom);
      cyc();
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // g = grant wait cycles, r = cycles from grant to rvalid minus one
  task automatic do_op(mem_op_t op, logic [31:0] a, logic [31:0] sd,
                       logic [31:0] rd, int g, int r);
    logic st = m_store(op);
    logic mis = m_mis(op, a);
    req_valid = 1'b1; mem_op = op; addr = a; store_data = sd;
    mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
    e_ready = 1'b1; e_req = 1'b0; e_rsp = 1'b0;
    cyc();
    req_valid = 1'b0; addr = $urandom; store_data = $urandom;
    mem_op = mem_op_t'(3'($urandom_range(0, 7)));
    e_ready = 1'b0;
    if (mis) begin
      mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom);
      e_rsp = 1'b1; e_mis = 1'b1; e_out = '0;
      cyc();
    end else begin
      e_req = 1'b1; e_addr = a & 32'hFFFFFFFC; e_we = st;
      e_mask = m_mask(op, a); e_wdata = m_wdata(op, sd);
      for (int i = 0; i <= g; i++) begin
        mem_gnt = (i == g); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        cyc();
      end
      e_req = 1'b0; mem_gnt = 1'b0;
      if (!st) begin
        for (int j = 0; j <= r; j++) begin
          mem_rvalid = (j == r); mem_rdata = (j == r) ? rd : $urandom;
          cyc();
        end
      end
      mem_gnt = 1'($urandom); mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      e_rsp = 1'b1; e_mis = 1'b0; e_out = st ? 32'h0 : m_load(op, a, rd);
      cyc();
    end
    e_rsp = 1'b0; e_ready = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  localparam logic [31:0] RD = 32'h80F17F01;

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_op = MEM_LB; addr = '0; store_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    e_ready = 1'b1; e_req = 1'b0; e_we = 1'b0; e_rsp = 1'b0; e_mis = 1'b0;
    e_addr = '0; e_wdata = '0; e_out = '0; e_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_wmask", 32'(mem_wmask), 32'h0);
    rst = 1'b0;
    cyc();

    // pin the model against hand-computed values
    chk("model_lb", m_load(MEM_LB, 32'h2, RD), 32'hFFFFFFF1);
    chk("model_lbu", m_load(MEM_LBU, 32'h3, RD), 32'h00000080);
    chk("model_lh", m_load(MEM_LH, 32'h2, RD), 32'hFFFF80F1);
    chk("model_lhu", m_load(MEM_LHU, 32'h0, RD), 32'h00007F01);
    chk("model_sb_mask", 32'(m_mask(MEM_SB, 32'h103)), 32'h8);
    chk("model_sb_wdata", m_wdata(MEM_SB, 32'hA5), 32'hA5A5A5A5);
    chk("model_sh_mask", 32'(m_mask(MEM_SH, 32'h102)), 32'hC);
    chk("model_sh_wdata", m_wdata(MEM_SH, 32'h1234), 32'h12341234);

    // directed cases
    do_op(MEM_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("sw_rsp_data", rsp_data, 32'h0);
    do_op(MEM_SB, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    do_op(MEM_SH, 32'h102, 32'h00001234, 32'h0, 0, 0);
    do_op(MEM_LB, 32'h2, 32'h0, RD, 0, 0);
    chk("lit_lb", rsp_data, 32'hFFFFFFF1);
    do_op(MEM_LBU, 32'h3, 32'h0, RD, 0, 0);
    chk("lit_lbu", rsp_data, 32'h00000080);
    do_op(MEM_LH, 32'h2, 32'h0, RD, 0, 0);
    chk("lit_lh", rsp_data, 32'hFFFF80F1);
    do_op(MEM_LHU, 32'h0, 32'h0, RD, 0, 0);
    chk("lit_lhu", rsp_data, 32'h00007F01);
    do_op(MEM_LW, 32'h0, 32'h0, RD, 0, 0);
    chk("lit_lw", rsp_data, 32'h80F17F01);
    do_op(MEM_LW, 32'h102, 32'h0, RD, 0, 0);
    chk("lit_mis_lw", 32'(rsp_misaligned), 32'h1);
    do_op(MEM_SH, 32'h101, 32'hFFFF, RD, 0, 0);
    chk("lit_mis_sh_data", rsp_data, 32'h0);
    do_op(MEM_LW, 32'h200, 32'h0, 32'hCAFEF00D, 3, 1);
    chk("lit_stall_lw", rsp_data, 32'hCAFEF00D);
    idle(2);

    // reset while a read is outstanding
    req_valid = 1'b1; mem_op = MEM_LW; addr = 32'h40;
    e_ready = 1'b1;
    cyc();
    req_valid = 1'b0; e_ready = 1'b0; e_req = 1'b1; e_addr = 32'h40; e_we = 1'b0; e_mask = 4'h0;
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0; e_req = 1'b0;
    cyc();
    rst = 1'b1;
    e_ready = 1'b1; e_out = '0; e_mis = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    cyc();
    mem_rvalid = 1'b0;
    repeat (3) cyc();
    chk("rst_mem_addr", mem_addr, 32'h0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a = $urandom;
      do_op(mem_op_t'(3'($urandom_range(0, 7))), a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
